// File: rtl/boot_pkg.sv
// rtl/boot_pkg.sv - shared state type and width helpers for the boot sequencer
package boot_pkg;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RUN,
    ST_DONE,
    ST_ERR
  } boot_state_t;

  function automatic int stage_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter that must hold the value x itself; never narrower than one bit.
  function automatic int cnt_w(input int x);
    return (x > 0) ? $clog2(x + 1) : 1;
  endfunction

endpackage

// File: rtl/boot_rx_router.sv
// rtl/boot_rx_router.sv - steers the UART byte handshake to the single owning stage
module boot_rx_router
  import boot_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int STAGE_W    = 2
) (
  input  boot_state_t             i_mode,
  input  logic [STAGE_W-1:0]      i_owner,
  input  logic                    i_rx_valid,
  output logic                    o_rx_ready,
  output logic [NUM_STAGES-1:0]   o_client_valid,
  input  logic [NUM_STAGES-1:0]   i_client_ready
);

  always_comb begin
    o_client_valid = '0;
    o_rx_ready     = 1'b0;
    case (i_mode)
      ST_RUN, ST_DONE: begin
        o_client_valid[i_owner] = i_rx_valid;
        o_rx_ready              = i_client_ready[i_owner];
      end
      // Nobody owns the stream after a timeout, so bytes are drained and dropped.
      ST_ERR:  o_rx_ready = 1'b1;
      default: o_rx_ready = 1'b0;
    endcase
  end

endmodule

// File: rtl/boot_sequencer.sv
// rtl/boot_sequencer.sv - ordered reset release of boot stages with rx ownership and timeout
module boot_sequencer
  import boot_pkg::*;
#(
  parameter int NUM_STAGES     = 3,
  parameter int HOLD_CYCLES    = 15,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          restart_req,
  input  logic [NUM_STAGES-1:0]         stage_done,
  output logic [NUM_STAGES-1:0]         stage_reset,
  input  logic                          rx_valid,
  input  logic [7:0]                    rx_data,
  output logic                          rx_ready,
  output logic [NUM_STAGES-1:0]         client_rx_valid,
  output logic [7:0]                    client_rx_data,
  input  logic [NUM_STAGES-1:0]         client_rx_ready,
  output logic [stage_w(NUM_STAGES)-1:0] active_stage,
  output logic                          all_done,
  output logic                          timeout_err
);

  localparam int STAGE_W = stage_w(NUM_STAGES);
  localparam int HOLD_W  = cnt_w(HOLD_CYCLES);
  localparam int RUN_W   = cnt_w(TIMEOUT_CYCLES);

  localparam logic [NUM_STAGES-1:0] ALL_RESET  = '1;
  localparam logic [NUM_STAGES-1:0] RUN0_RESET = ALL_RESET << 1;
  localparam logic [STAGE_W-1:0]    FINAL_IDX  = STAGE_W'(NUM_STAGES - 1);
  localparam logic [STAGE_W-1:0]    LAST_RUN   = STAGE_W'(NUM_STAGES - 2);
  localparam logic [HOLD_W-1:0]     HOLD_INIT  = HOLD_W'(HOLD_CYCLES);
  localparam logic [RUN_W-1:0]      RUN_LAST   = RUN_W'(TIMEOUT_CYCLES - 1);

  boot_state_t            r_state;
  logic [HOLD_W-1:0]      r_hold_cnt;
  logic [RUN_W-1:0]       r_run_cnt;
  logic [NUM_STAGES-1:0]  r_stage_reset;
  logic [STAGE_W-1:0]     r_active_stage;
  logic                   r_all_done;
  logic                   r_timeout_err;

  logic                   w_done;
  logic [STAGE_W-1:0]     w_next_idx;

  assign w_done     = stage_done[r_active_stage];
  assign w_next_idx = r_active_stage + STAGE_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_HOLD;
      r_hold_cnt     <= HOLD_INIT;
      r_run_cnt      <= '0;
      r_stage_reset  <= ALL_RESET;
      r_active_stage <= '0;
      r_all_done     <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else if (restart_req) begin
      r_state        <= ST_HOLD;
      r_hold_cnt     <= HOLD_INIT;
      r_run_cnt      <= '0;
      r_stage_reset  <= ALL_RESET;
      r_active_stage <= '0;
      r_all_done     <= 1'b0;
      r_timeout_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_HOLD: begin
          // Leaving on the 1->0 step gives exactly HOLD_CYCLES cycles in HOLD.
          if (r_hold_cnt <= HOLD_W'(1)) begin
            r_hold_cnt <= '0;
            r_run_cnt  <= '0;
            if (NUM_STAGES == 1) begin
              r_state        <= ST_DONE;
              r_stage_reset  <= '0;
              r_active_stage <= FINAL_IDX;
              r_all_done     <= 1'b1;
            end else begin
              r_state        <= ST_RUN;
              r_stage_reset  <= RUN0_RESET;
              r_active_stage <= '0;
            end
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end
        ST_RUN: begin
          if (w_done) begin
            r_run_cnt <= '0;
            if (r_active_stage == LAST_RUN) begin
              r_state        <= ST_DONE;
              r_stage_reset  <= '0;
              r_active_stage <= FINAL_IDX;
              r_all_done     <= 1'b1;
            end else begin
              r_active_stage            <= w_next_idx;
              r_stage_reset[w_next_idx] <= 1'b0;
            end
          end else if (TIMEOUT_CYCLES != 0) begin
            if (r_run_cnt == RUN_LAST) begin
              r_state       <= ST_ERR;
              r_stage_reset <= ALL_RESET;
              r_timeout_err <= 1'b1;
            end else begin
              r_run_cnt <= r_run_cnt + RUN_W'(1);
            end
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase
    end
  end

  boot_rx_router #(
    .NUM_STAGES (NUM_STAGES),
    .STAGE_W    (STAGE_W)
  ) u_router (
    .i_mode         (r_state),
    .i_owner        (r_active_stage),
    .i_rx_valid     (rx_valid),
    .o_rx_ready     (rx_ready),
    .o_client_valid (client_rx_valid),
    .i_client_ready (client_rx_ready)
  );

  assign client_rx_data = rx_data;
  assign stage_reset    = r_stage_reset;
  assign active_stage   = r_active_stage;
  assign all_done       = r_all_done;
  assign timeout_err    = r_timeout_err;

endmodule

// File: tb/tb_boot_sequencer.sv
// tb/tb_boot_sequencer.sv - directed and randomized checks of boot_sequencer against a cycle model
module tb_boot_sequencer;

  localparam int NS = 3;
  localparam int H  = 15;
  localparam int T  = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        restart_req = 1'b0;
  logic [2:0]  stage_done = '0;
  logic [2:0]  stage_reset;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_ready;
  logic [2:0]  client_rx_valid;
  logic [7:0]  client_rx_data;
  logic [2:0]  client_rx_ready = '0;
  logic [1:0]  active_stage;
  logic        all_done;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  int n;

  // Model: m_stage -1 while held, k while stage k runs, NS-1 once finished.
  int m_stage;
  bit m_err;
  int m_hold_left;
  int m_age;

  always #5 clk = ~clk;

  boot_sequencer #(
    .NUM_STAGES     (NS),
    .HOLD_CYCLES    (H),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .restart_req     (restart_req),
    .stage_done      (stage_done),
    .stage_reset     (stage_reset),
    .rx_valid        (rx_valid),
    .rx_data         (rx_data),
    .rx_ready        (rx_ready),
    .client_rx_valid (client_rx_valid),
    .client_rx_data  (client_rx_data),
    .client_rx_ready (client_rx_ready),
    .active_stage    (active_stage),
    .all_done        (all_done),
    .timeout_err     (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stage     = -1;
    m_err       = 1'b0;
    m_hold_left = (H > 0) ? H : 1;
    m_age       = 0;
  endtask

  task automatic model_step();
    if (restart_req) begin
      model_reset();
    end else if (m_err) begin
      m_err = 1'b1;
    end else if (m_stage < 0) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_stage = (NS == 1) ? NS - 1 : 0;
        m_age   = 0;
      end
    end else if (m_stage < NS - 1) begin
      if (stage_done[m_stage]) begin
        m_stage++;
        m_age = 0;
      end else begin
        m_age++;
        if (T > 0 && m_age >= T) m_err = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    logic [2:0] e_reset;
    logic [2:0] e_valid;
    logic       e_ready;
    e_valid = '0;
    e_ready = 1'b0;
    if (m_err || m_stage < 0) e_reset = 3'b111;
    else                      e_reset = 3'(7 & ~((1 << (m_stage + 1)) - 1));
    if (m_err) begin
      e_ready = 1'b1;
    end else if (m_stage >= 0) begin
      e_valid = 3'(int'(rx_valid) << m_stage);
      e_ready = client_rx_ready[m_stage];
    end
    chk("stage_reset", stage_reset, e_reset);
    chk("all_done", all_done, (!m_err && m_stage == NS - 1));
    chk("timeout_err", timeout_err, m_err);
    if (!m_err) chk("active_stage", active_stage, (m_stage < 0) ? 0 : m_stage);
    chk("client_rx_valid", client_rx_valid, e_valid);
    chk("rx_ready", rx_ready, e_ready);
    chk("client_rx_data", client_rx_data, rx_data);
  endtask

  task automatic cycle();
    #1 check_all();
    @(posedge clk);
    model_step();
    #1 check_all();
  endtask

  initial begin
    rx_valid = 1'b1;
    rx_data = 8'h11;
    client_rx_ready = 3'b111;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check_all();
    chk("reset_stage_reset", stage_reset, 3'b111);
    chk("reset_rx_ready", rx_ready, 1'b0);
    reset = 1'b0;

    n = 0;
    while (stage_reset == 3'b111 && n < 40) begin
      chk("hold_rx_ready", rx_ready, 1'b0);
      n++;
      cycle();
    end
    chk("hold_len", n, H);
    chk("first_release", stage_reset, 3'b110);

    rx_data = 8'hA5;
    stage_done = 3'b001;
    #1;
    chk("a5_valid", client_rx_valid, 3'b001);
    chk("a5_data", client_rx_data, 8'hA5);
    chk("a5_ready", rx_ready, 1'b1);
    cycle();
    chk("stage1_reset", stage_reset, 3'b100);
    chk("stage1_active", active_stage, 1);
    stage_done = 3'b000;
    rx_data = 8'h3C;
    client_rx_ready = 3'b101;
    #1;
    chk("3c_valid", client_rx_valid, 3'b010);
    chk("3c_stall", rx_ready, 1'b0);
    client_rx_ready = 3'b111;
    stage_done = 3'b010;
    cycle();
    stage_done = 3'b000;
    chk("done_reset", stage_reset, 3'b000);
    chk("done_all", all_done, 1'b1);
    chk("done_active", active_stage, 2);

    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_stage_reset", stage_reset, 3'b111);
    chk("async_all_done", all_done, 1'b0);
    chk("async_active", active_stage, 0);
    chk("async_rx_ready", rx_ready, 1'b0);
    chk("async_valid", client_rx_valid, 3'b000);
    @(posedge clk);
    #1 reset = 1'b0;

    n = 0;
    while (stage_reset == 3'b111 && n < 40) begin
      n++;
      cycle();
    end
    chk("rehold_len", n, H);
    n = 0;
    while (!timeout_err && n < 40) begin
      n++;
      cycle();
    end
    chk("timeout_len", n, T);
    client_rx_ready = 3'b000;
    #1;
    chk("err_flag", timeout_err, 1'b1);
    chk("err_reset", stage_reset, 3'b111);
    chk("err_rx_ready", rx_ready, 1'b1);
    chk("err_valid", client_rx_valid, 3'b000);
    client_rx_ready = 3'b111;

    restart_req = 1'b1;
    cycle();
    restart_req = 1'b0;
    chk("restart_clears_err", timeout_err, 1'b0);
    n = 0;
    while (stage_reset == 3'b111 && n < 40) begin
      n++;
      cycle();
    end
    chk("restart_hold_len", n, H);
    stage_done = 3'b001;
    cycle();
    stage_done = 3'b000;
    cycle();
    stage_done = 3'b010;
    restart_req = 1'b1;
    cycle();
    restart_req = 1'b0;
    stage_done = 3'b000;
    chk("midrun_restart_reset", stage_reset, 3'b111);
    chk("midrun_restart_err", timeout_err, 1'b0);
    chk("midrun_restart_active", active_stage, 0);
    chk("midrun_restart_done", all_done, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      rx_valid        = 1'($urandom_range(0, 1));
      rx_data         = 8'($urandom);
      client_rx_ready = 3'($urandom);
      for (int b = 0; b < NS; b++) stage_done[b] = ($urandom_range(0, 5) == 0);
      restart_req     = ($urandom_range(0, 59) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
